// File: rtl/bp_perf_monitor.sv
// rtl/bp_perf_monitor.sv - branch predictor performance monitor with windowed event counters
module bp_perf_monitor #(
  parameter int unsigned CNT_W     = 32,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             stop_i,
  input  logic             clear_i,
  input  logic [CNT_W-1:0] window_i,
  input  logic             br_misses_i,
  input  logic             br_instr_i,
  input  logic [31:0]      instr_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [CNT_W-1:0] cycle_cnt_o,
  output logic [CNT_W-1:0] instr_cnt_o,
  output logic [CNT_W-1:0] br_cnt_o,
  output logic [CNT_W-1:0] miss_cnt_o,
  output logic             sat_o
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_e           state_q;
  logic [CNT_W-1:0] win_q;
  logic [CNT_W-1:0] cycle_q, instr_q, br_q, miss_q;
  logic [CNT_W-1:0] cycle_d, instr_d, br_d, miss_d;
  logic             sat_q, done_q, busy_q;
  logic             instr_ev;
  logic             sat_hit;
  logic             win_hit;
  logic             end_run;

  // Saturating increment: a counter parked at all-ones stays there.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
    if (en && (v != CNT_MAX)) begin
      return v + CNT_ONE;
    end
    return v;
  endfunction

  // Next counter values for one RUN cycle and the window-termination decision.
  always_comb begin
    instr_ev = (instr_i != NOP_INSTR) && (instr_i != 32'd0);
    cycle_d  = sat_inc(cycle_q, 1'b1);
    instr_d  = sat_inc(instr_q, instr_ev);
    br_d     = sat_inc(br_q, br_instr_i);
    miss_d   = sat_inc(miss_q, br_misses_i);
    sat_hit  = (cycle_q == CNT_MAX)
             | (instr_ev    & (instr_q == CNT_MAX))
             | (br_instr_i  & (br_q    == CNT_MAX))
             | (br_misses_i & (miss_q  == CNT_MAX));
    // Termination compares the post-increment cycle count, so the last cycle is counted.
    win_hit  = (win_q != '0) && (cycle_d == win_q);
    end_run  = stop_i || win_hit;
  end

  // Control FSM plus all counters; clear_i outranks every other command.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      win_q   <= '0;
      cycle_q <= '0;
      instr_q <= '0;
      br_q    <= '0;
      miss_q  <= '0;
      sat_q   <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else if (clear_i) begin
      state_q <= ST_IDLE;
      win_q   <= '0;
      cycle_q <= '0;
      instr_q <= '0;
      br_q    <= '0;
      miss_q  <= '0;
      sat_q   <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          done_q <= 1'b0;
          if (start_i) begin
            state_q <= ST_RUN;
            busy_q  <= 1'b1;
            win_q   <= window_i;
            cycle_q <= '0;
            instr_q <= '0;
            br_q    <= '0;
            miss_q  <= '0;
            sat_q   <= 1'b0;
          end
        end
        ST_RUN: begin
          cycle_q <= cycle_d;
          instr_q <= instr_d;
          br_q    <= br_d;
          miss_q  <= miss_d;
          if (sat_hit) begin
            sat_q <= 1'b1;
          end
          if (end_run) begin
            state_q <= ST_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign cycle_cnt_o = cycle_q;
  assign instr_cnt_o = instr_q;
  assign br_cnt_o    = br_q;
  assign miss_cnt_o  = miss_q;
  assign sat_o       = sat_q;

endmodule

// File: tb/tb_bp_perf_monitor.sv
// tb/tb_bp_perf_monitor.sv - randomized and directed self-checking bench for bp_perf_monitor
module tb_bp_perf_monitor;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk;
  logic        rst;
  logic        start_in, stop_in, clr_in, br_in, ms_in;
  logic [31:0] win_in;
  logic [31:0] instr_in;

  logic        busy0, done0, sat0;
  logic [31:0] cyc0, ins0, br0, ms0;
  logic        busy1, done1, sat1;
  logic [3:0]  cyc1, ins1, br1, ms1;

  int n_total;
  int n_bad;

  // Reference model: per instance, unbounded event counts inside the current window.
  int     m_st[2];
  longint m_win[2];
  longint m_cyc[2], m_ins[2], m_br[2], m_ms[2];
  bit     m_done[2];
  longint mx[2];

  bp_perf_monitor dut (
    .clk_i(clk), .rst_i(rst), .start_i(start_in), .stop_i(stop_in), .clear_i(clr_in),
    .window_i(win_in), .br_misses_i(ms_in), .br_instr_i(br_in), .instr_i(instr_in),
    .busy_o(busy0), .done_o(done0), .cycle_cnt_o(cyc0), .instr_cnt_o(ins0),
    .br_cnt_o(br0), .miss_cnt_o(ms0), .sat_o(sat0)
  );

  bp_perf_monitor #(.CNT_W(4)) dut_s (
    .clk_i(clk), .rst_i(rst), .start_i(start_in), .stop_i(stop_in), .clear_i(clr_in),
    .window_i(win_in[3:0]), .br_misses_i(ms_in), .br_instr_i(br_in), .instr_i(instr_in),
    .busy_o(busy1), .done_o(done1), .cycle_cnt_o(cyc1), .instr_cnt_o(ins1),
    .br_cnt_o(br1), .miss_cnt_o(ms1), .sat_o(sat1)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic longint clip(input longint raw, input longint lim);
    return (raw > lim) ? lim : raw;
  endfunction

  task automatic m_zero(input int i);
    m_cyc[i] = 0; m_ins[i] = 0; m_br[i] = 0; m_ms[i] = 0;
  endtask

  task automatic m_reset(input int i);
    m_st[i] = 0; m_win[i] = 0; m_done[i] = 0;
    m_zero(i);
  endtask

  task automatic m_step(input int i);
    if (rst || clr_in) begin
      m_reset(i);
    end else if (m_st[i] == 1) begin
      m_done[i] = 0;
      m_cyc[i]++;
      if (instr_in != NOP && instr_in != 32'd0) m_ins[i]++;
      if (br_in) m_br[i]++;
      if (ms_in) m_ms[i]++;
      if (stop_in || (m_win[i] != 0 && clip(m_cyc[i], mx[i]) == m_win[i])) begin
        m_st[i]   = 2;
        m_done[i] = 1;
      end
    end else begin
      m_done[i] = 0;
      if (start_in) begin
        m_st[i]  = 1;
        m_win[i] = longint'(win_in) & mx[i];
        m_zero(i);
      end
    end
  endtask

  task automatic check_outs();
    bit s0, s1;
    s0 = (m_cyc[0] > mx[0]) || (m_ins[0] > mx[0]) || (m_br[0] > mx[0]) || (m_ms[0] > mx[0]);
    s1 = (m_cyc[1] > mx[1]) || (m_ins[1] > mx[1]) || (m_br[1] > mx[1]) || (m_ms[1] > mx[1]);
    check("busy0", 64'(busy0), 64'(m_st[0] == 1));
    check("done0", 64'(done0), 64'(m_done[0]));
    check("cyc0",  64'(cyc0),  clip(m_cyc[0], mx[0]));
    check("ins0",  64'(ins0),  clip(m_ins[0], mx[0]));
    check("br0",   64'(br0),   clip(m_br[0], mx[0]));
    check("miss0", 64'(ms0),   clip(m_ms[0], mx[0]));
    check("sat0",  64'(sat0),  64'(s0));
    check("busy1", 64'(busy1), 64'(m_st[1] == 1));
    check("done1", 64'(done1), 64'(m_done[1]));
    check("cyc1",  64'(cyc1),  clip(m_cyc[1], mx[1]));
    check("ins1",  64'(ins1),  clip(m_ins[1], mx[1]));
    check("br1",   64'(br1),   clip(m_br[1], mx[1]));
    check("miss1", 64'(ms1),   clip(m_ms[1], mx[1]));
    check("sat1",  64'(sat1),  64'(s1));
  endtask

  // Inputs are set at the falling edge, the model advances at the rising edge.
  task automatic tick();
    @(posedge clk);
    m_step(0);
    m_step(1);
    @(negedge clk);
    check_outs();
  endtask

  task automatic idle_in();
    start_in = 0; stop_in = 0; clr_in = 0; br_in = 0; ms_in = 0;
    instr_in = NOP;
  endtask

  task automatic begin_window(input logic [31:0] w);
    idle_in();
    clr_in = 1;
    tick();
    clr_in   = 0;
    win_in   = w;
    start_in = 1;
    tick();
    start_in = 0;
  endtask

  task automatic async_reset();
    #2 rst = 1;
    #1;
    m_reset(0);
    m_reset(1);
    check_outs();
    check("arst_busy", 64'(busy0), 64'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 0;
    check_outs();
  endtask

  initial begin
    int pulses;
    clk = 0; rst = 1; win_in = 0;
    n_total = 0; n_bad = 0;
    idle_in();
    mx[0] = 64'h0000_0000_FFFF_FFFF;
    mx[1] = 15;
    m_reset(0);
    m_reset(1);
    @(negedge clk);
    check_outs();
    check("rst_busy", 64'(busy0), 64'd0);
    check("rst_cyc",  64'(cyc0),  64'd0);
    rst = 0;
    start_in = 0;
    tick();
    check("idle_stay", 64'(busy0), 64'd0);

    // Fixed 10-cycle window with scattered branch events and only NOPs.
    begin_window(32'd10);
    for (int k = 1; k <= 10; k++) begin
      br_in = (k == 2 || k == 5 || k == 7);
      ms_in = (k == 5);
      tick();
    end
    check("w10_done", 64'(done0), 64'd1);
    check("w10_cyc",  64'(cyc0),  64'd10);
    check("w10_ins",  64'(ins0),  64'd0);
    check("w10_br",   64'(br0),   64'd3);
    check("w10_miss", 64'(ms0),   64'd1);
    idle_in();
    tick();
    check("w10_pulse", 64'(done0), 64'd0);

    // Unbounded window ended by stop on the 25th cycle.
    begin_window(32'd0);
    for (int k = 1; k <= 25; k++) begin
      instr_in = 32'h00A0_0093;
      stop_in  = (k == 25);
      tick();
    end
    check("stop_cyc",  64'(cyc0),  64'd25);
    check("stop_ins",  64'(ins0),  64'd25);
    check("stop_done", 64'(done0), 64'd1);
    idle_in();
    pulses = 0;
    for (int k = 0; k < 3; k++) begin
      tick();
      pulses += int'(done0);
    end
    check("stop_pulses", 64'(pulses), 64'd0);
    check("stop_hold",   64'(cyc0),   64'd25);

    // Single-cycle window.
    begin_window(32'd1);
    check("w1_busy", 64'(busy0), 64'd1);
    tick();
    check("w1_done", 64'(done0), 64'd1);
    check("w1_cyc",  64'(cyc0),  64'd1);
    check("w1_idle", 64'(busy0), 64'd0);

    // Saturation on the 4-bit instance.
    begin_window(32'd0);
    for (int k = 1; k <= 20; k++) begin
      ms_in   = 1;
      stop_in = (k == 20);
      tick();
    end
    check("sat_miss4", 64'(ms1),  64'd15);
    check("sat_cyc4",  64'(cyc1), 64'd15);
    check("sat_flag4", 64'(sat1), 64'd1);
    check("sat_miss",  64'(ms0),  64'd20);
    check("sat_none",  64'(sat0), 64'd0);

    // Clear wins over simultaneous start and stop.
    begin_window(32'd0);
    for (int k = 1; k <= 5; k++) begin
      br_in = 1;
      tick();
    end
    start_in = 1; clr_in = 1; stop_in = 1;
    tick();
    check("clr_busy", 64'(busy0), 64'd0);
    check("clr_cyc",  64'(cyc0),  64'd0);
    check("clr_done", 64'(done0), 64'd0);
    idle_in();
    tick();
    check("clr_nodone", 64'(done0), 64'd0);

    // Asynchronous reset in the middle of a window, then a clean rerun.
    begin_window(32'd10);
    for (int k = 1; k <= 3; k++) tick();
    async_reset();
    pulses = 0;
    for (int k = 0; k < 12; k++) begin
      tick();
      pulses += int'(done0);
    end
    check("arst_nodone", 64'(pulses), 64'd0);
    begin_window(32'd10);
    for (int k = 1; k <= 10; k++) tick();
    check("rerun_done", 64'(done0), 64'd1);
    check("rerun_cyc",  64'(cyc0),  64'd10);

    // Randomized traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      rst      = ($urandom_range(0, 399) == 0);
      clr_in   = ($urandom_range(0, 59) == 0);
      start_in = ($urandom_range(0, 7) == 0);
      stop_in  = ($urandom_range(0, 24) == 0);
      win_in   = ($urandom_range(0, 3) == 0) ? 32'd0 : 32'($urandom_range(1, 40));
      br_in    = 1'($urandom_range(0, 1));
      ms_in    = ($urandom_range(0, 3) == 0);
      case ($urandom_range(0, 3))
        0:       instr_in = NOP;
        1:       instr_in = 32'd0;
        default: instr_in = $urandom;
      endcase
      tick();
    end
    rst = 0;

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/bp_perf_monitor.md
BP_PERF_MONITOR -- requirements
Module: bp_perf_monitor

Interface
REQ-001 SHALL have parameter CNT_W, default 32, width of every event counter.
REQ-002 SHALL have parameter NOP_INSTR, default 32'h0000_0013, encoding excluded from instruction counting.
REQ-003 SHALL have port clk_i  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst_i  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port start_i  input  1  begin measurement window.
REQ-006 SHALL have port stop_i  input  1  end measurement window early.
REQ-007 SHALL have port clear_i  input  1  abort and zero all counters.
REQ-008 SHALL have port window_i  input  CNT_W  window length in cycles; 0 = unbounded.
REQ-009 SHALL have port br_misses_i  input  1  per-cycle pipeline flush (mispredict) event.
REQ-010 SHALL have port br_instr_i  input  1  per-cycle branch/jump resolved in EX.
REQ-011 SHALL have port instr_i  input  32  instruction currently fetched in IF.
REQ-012 SHALL have port busy_o  output  1  high while in RUN.
REQ-013 SHALL have port done_o  output  1  one-cycle pulse on window completion.
REQ-014 SHALL have ports cycle_cnt_o, instr_cnt_o, br_cnt_o, miss_cnt_o  output  CNT_W each  registered counter values.
REQ-015 SHALL have port sat_o  output  1  sticky flag: some counter saturated this window.

Function
REQ-016 SHALL implement FSM states IDLE, RUN, DONE; all outputs registered.
REQ-017 IDLE: start_i=1 -> RUN next cycle; all four counters and sat_o zeroed on that edge; window_i latched into internal window register.
REQ-018 RUN, per cycle: cycle_cnt +1; instr_cnt +1 iff instr_i != NOP_INSTR and instr_i != 0; br_cnt +1 iff br_instr_i; miss_cnt +1 iff br_misses_i; events in same cycle counted independently.
REQ-019 Events SHALL be sampled only in RUN; inputs in IDLE/DONE ignored, and the start cycle itself is not counted.
REQ-020 RUN -> DONE when stop_i=1, or latched window != 0 and post-increment cycle_cnt == window; the terminating cycle's events ARE counted.
REQ-021 done_o SHALL be 1 for exactly the first cycle in DONE; counters frozen in DONE.
REQ-022 DONE: start_i=1 -> RUN with counters re-zeroed (as REQ-017); otherwise hold DONE.
REQ-023 start_i in RUN SHALL be ignored.
REQ-024 clear_i SHALL have priority over start_i and stop_i in every state: next state IDLE, counters and sat_o zero, done_o 0.
REQ-025 Counters SHALL saturate at 2^CNT_W-1 (no wrap); any increment attempt at max sets sat_o, held until next start/clear/reset.
REQ-026 busy_o = (state == RUN).
REQ-027 miss_cnt may exceed br_cnt (flush without EX branch flag); no cross-check performed.

Reset
REQ-028 rst_i=1 SHALL asynchronously force state IDLE, all counters 0, sat_o 0, done_o 0, busy_o 0, latched window 0.
REQ-029 rst_i asserted mid-RUN SHALL discard the window; no done_o pulse after release.
REQ-030 After rst_i deassertion block SHALL remain in IDLE until start_i.

Verification
REQ-031 window_i=10, start_i pulse, br_instr_i high cycles 2,5,7, br_misses_i high cycle 5, instr_i=NOP throughout -> done_o pulse after 10 RUN cycles; cycle=10, instr=0, br=3, miss=1.
REQ-032 window_i=0, start, 25 cycles of instr_i=32'h00A00093, stop_i on 25th -> cycle=25, instr=25, DONE held, done_o single pulse.
REQ-033 window_i=1 -> exactly one RUN cycle, cycle=1, busy_o high one cycle, done_o next.
REQ-034 CNT_W=4, window_i=0, br_misses_i constant 1 for 20 cycles -> miss=15, cycle=15, sat_o=1, no wrap.
REQ-035 start, clear_i and stop_i same cycle at RUN cycle 6 -> IDLE, all counters 0, no done_o.
REQ-036 rst_i pulse at RUN cycle 4 of window 10 -> immediate zero outputs, busy_o 0, no done_o; later start runs full 10-cycle window correctly.
